// File: rtl/dmem_responder_if.sv
// Core data-bus bundle between a req/gnt/rvalid master and a memory responder.
interface dmem_responder_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [6:0]  data_wdata_intg;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [6:0]  data_rdata_intg;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
    input  data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
    output data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target for the core's req/gnt/rvalid bus: byte-lane RAM, programmable
// grant wait states and response latency, error response outside the mapped window.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned GNT_WAIT    = 0,
  parameter int unsigned RVALID_LAT  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LAST = 3'(GNT_WAIT);
  localparam logic [1:0]  LAT_LOAD  = 2'(RVALID_LAT - 1);
  localparam logic        NO_WAIT   = (GNT_WAIT == 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [2:0]    wcnt_reg, wcnt_next;
  logic [1:0]    lcnt_reg, lcnt_next;
  logic          rvalid_reg, rvalid_next;
  logic          err_reg, err_next;
  logic          err_pend_reg, err_pend_next;
  logic          rd_ok_reg, rd_ok_next;
  logic [31:0]   hold_reg;
  logic [31:0]   capture_word;
  logic [31:0]   rdata_out;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          gnt;
  logic          acc_write;
  logic          acc_read;
  logic          unused_bits;

  // The window is aligned to its own size, so range decode is a tag compare.
  assign in_range = (bus.data_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign word_idx = bus.data_addr[AW+1:2];

  always_comb begin
    gnt = 1'b0;
    if (rst_ni && bus.data_req) begin
      case (state_reg)
        ST_IDLE: gnt = NO_WAIT;
        ST_WAIT: gnt = (wcnt_reg == WAIT_LAST);
        ST_RESP: gnt = rvalid_reg && NO_WAIT;
        default: gnt = 1'b0;
      endcase
    end
  end

  assign acc_write = gnt && bus.data_we && in_range;
  assign acc_read  = gnt && !bus.data_we && in_range;

  always_comb begin
    state_next    = state_reg;
    wcnt_next     = wcnt_reg;
    lcnt_next     = lcnt_reg;
    err_pend_next = err_pend_reg;
    rd_ok_next    = rd_ok_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.data_req && !NO_WAIT) begin
          state_next = ST_WAIT;
          wcnt_next  = 3'd1;
        end
      end
      ST_WAIT: begin
        if (!bus.data_req) begin
          state_next = ST_IDLE;
          wcnt_next  = 3'd0;
        end else if (wcnt_reg != WAIT_LAST) begin
          wcnt_next = wcnt_reg + 3'd1;
        end
      end
      ST_RESP: begin
        if (!rvalid_reg) begin
          lcnt_next = lcnt_reg - 2'd1;
        end else if (bus.data_req && !NO_WAIT) begin
          state_next = ST_WAIT;
          wcnt_next  = 3'd1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        wcnt_next  = 3'd0;
        lcnt_next  = 2'd0;
      end
    endcase

    // Acceptance overrides the per-state decision, including back-to-back in RESP.
    if (gnt) begin
      state_next    = ST_RESP;
      wcnt_next     = 3'd0;
      lcnt_next     = LAT_LOAD;
      err_pend_next = !in_range;
      rd_ok_next    = !bus.data_we && in_range;
    end

    rvalid_next = (state_next == ST_RESP) && (lcnt_next == 2'd0);
    err_next    = rvalid_next && err_pend_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_IDLE;
      wcnt_reg     <= 3'd0;
      lcnt_reg     <= 2'd0;
      rvalid_reg   <= 1'b0;
      err_reg      <= 1'b0;
      err_pend_reg <= 1'b0;
      rd_ok_reg    <= 1'b0;
      hold_reg     <= 32'h0;
    end else begin
      state_reg    <= state_next;
      wcnt_reg     <= wcnt_next;
      lcnt_reg     <= lcnt_next;
      rvalid_reg   <= rvalid_next;
      err_reg      <= err_next;
      err_pend_reg <= err_pend_next;
      rd_ok_reg    <= rd_ok_next;
      if (rvalid_reg) begin
        hold_reg <= rdata_out;
      end
    end
  end

  // One RAM per byte lane keeps byte-enable writes a plain single-port write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk_i) begin
        if (acc_write && bus.data_be[gi]) begin
          lane_mem[word_idx] <= bus.data_wdata[8*gi +: 8];
        end
        if (acc_read) begin
          lane_q_reg <= lane_mem[word_idx];
        end
      end

      assign capture_word[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

  // Outside response cycles the read bus keeps showing the previous response.
  always_comb begin
    rdata_out = hold_reg;
    if (rvalid_reg) begin
      rdata_out = rd_ok_reg ? capture_word : 32'h0;
    end
  end

  assign bus.data_gnt        = gnt;
  assign bus.data_rvalid     = rvalid_reg;
  assign bus.data_err        = err_reg;
  assign bus.data_rdata      = rdata_out;
  assign bus.data_rdata_intg = 7'h0;

  assign unused_bits = ^{bus.data_wdata_intg, bus.data_addr[1:0]};

endmodule
